magazine_ctrl: RTL and testbench

MAGAZINE_CTRL -- requirements
Module: magazine_ctrl

---
 rtl/magazine_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_magazine_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magazine_ctrl.sv
// ---------------------------------------------------------------------------
// magazine_ctrl
//
// Ammunition magazine controller for the light-gun game. It tracks how many
// rounds are left and enforces a lockout after every shot. It also inserts
// rounds one at a time while the player holds the magazine in reload.
//
// Parameters
//   MAG_SIZE         magazine capacity in rounds (1..7)
//   COOLDOWN_CYCLES  post-shot lockout length in clk cycles (>=1)
//   RELOAD_CYCLES    time to insert one round in clk cycles (>=1)
//
// Ports
//   clk                  in   system clock, rising edge
//   rst                  in   synchronous active-high reset
//   game_enable          in   gameplay active (low = menu / idle screen)
//   round_start          in   one-cycle pulse starting a new duck round
//   trigger              in   fire-button level, synchronous to clk
//   reload_btn           in   reload-button level, synchronous to clk
//   bullets_in_magazine  out  rounds remaining (0..MAG_SIZE)
//   shot_fired           out  one-cycle pulse per accepted shot
//   dry_fire             out  one-cycle pulse per press on an empty magazine
//   reloading            out  high while reloading
//   ready                out  high when able to fire (READY with rounds left)
//
// All outputs are registered. A button press sampled at a clock edge shows
// its effect on the outputs directly after that same edge.
// ---------------------------------------------------------------------------
module magazine_ctrl #(
  parameter int MAG_SIZE        = 3,
  parameter int COOLDOWN_CYCLES = 6_500_000,
  parameter int RELOAD_CYCLES   = 32_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_enable,
  input  logic       round_start,
  input  logic       trigger,
  input  logic       reload_btn,
  output logic [2:0] bullets_in_magazine,
  output logic       shot_fired,
  output logic       dry_fire,
  output logic       reloading,
  output logic       ready
);

  // The shared down-counter only ever holds a value of at most
  // max(COOLDOWN_CYCLES, RELOAD_CYCLES) - 1.
  localparam int CNT_MAX = (COOLDOWN_CYCLES > RELOAD_CYCLES) ?
                           COOLDOWN_CYCLES : RELOAD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0]       MAG_FULL    = 3'(MAG_SIZE);
  localparam logic [CNT_W-1:0] COOL_LOAD   = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELOAD_LOAD = CNT_W'(RELOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_DISABLED = 2'd0,
    S_READY    = 2'd1,
    S_COOLDOWN = 2'd2,
    S_RELOAD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       count_q, count_d;
  logic [CNT_W-1:0] timer_q, timer_d;

  // Button history: the level seen at the previous clock edge.
  logic             trig_q;
  logic             reload_q;

  logic             shot_d;
  logic             dry_d;
  logic             shot_q;
  logic             dry_q;
  logic             reloading_q;
  logic             ready_q;

  logic             trig_press;
  logic             reload_press;
  logic             have_round;
  logic             timer_done;
  logic [2:0]       count_inc;

  assign trig_press   = trigger    & ~trig_q;
  assign reload_press = reload_btn & ~reload_q;
  assign have_round   = (count_q != 3'd0);
  assign timer_done   = (timer_q == '0);
  assign count_inc    = count_q + 3'd1;

  // -------------------------------------------------------------------------
  // Next-state logic. Precedence: game_enable low, then round_start, then
  // the per-state button handling.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    timer_d = timer_q;
    shot_d  = 1'b0;
    dry_d   = 1'b0;

    if (!game_enable) begin
      state_d = S_DISABLED;
      count_d = MAG_FULL;
      timer_d = '0;
    end else if (round_start) begin
      // A new duck round refills the magazine and drops any lockout/reload.
      state_d = S_READY;
      count_d = MAG_FULL;
      timer_d = '0;
    end else begin
      case (state_q)
        S_DISABLED: begin
          state_d = S_READY;
        end

        S_READY: begin
          // Trigger wins over a simultaneous reload press.
          if (trig_press) begin
            if (have_round) begin
              shot_d  = 1'b1;
              count_d = count_q - 3'd1;
              timer_d = COOL_LOAD;
              state_d = S_COOLDOWN;
            end else begin
              dry_d = 1'b1;
            end
          end else if (reload_press && (count_q < MAG_FULL)) begin
            timer_d = RELOAD_LOAD;
            state_d = S_RELOAD;
          end
        end

        S_COOLDOWN: begin
          // Buttons are ignored. The counter is loaded with N-1, so the
          // lockout lasts exactly N cycles including the zero cycle.
          if (timer_done) begin
            state_d = S_READY;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end

        S_RELOAD: begin
          if (trig_press && have_round) begin
            // Abort the reload and fire. A round that would have finished
            // on this very cycle is lost along with the partial one.
            shot_d  = 1'b1;
            count_d = count_q - 3'd1;
            timer_d = COOL_LOAD;
            state_d = S_COOLDOWN;
          end else begin
            // Only reachable with an empty magazine when trig_press is set.
            dry_d = trig_press;
            if (timer_done) begin
              count_d = count_inc;
              if (count_inc == MAG_FULL) begin
                state_d = S_READY;
              end else begin
                timer_d = RELOAD_LOAD;
              end
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end

        default: begin
          state_d = S_DISABLED;
          count_d = MAG_FULL;
          timer_d = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State and registered outputs. The status outputs are derived from the
  // next state, so they line up with the state register.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_DISABLED;
      count_q     <= MAG_FULL;
      timer_q     <= '0;
      trig_q      <= 1'b0;
      reload_q    <= 1'b0;
      shot_q      <= 1'b0;
      dry_q       <= 1'b0;
      reloading_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      trig_q      <= trigger;
      reload_q    <= reload_btn;
      shot_q      <= shot_d;
      dry_q       <= dry_d;
      reloading_q <= (state_d == S_RELOAD);
      ready_q     <= (state_d == S_READY) && (count_d != 3'd0);
    end
  end

  assign bullets_in_magazine = count_q;
  assign shot_fired          = shot_q;
  assign dry_fire            = dry_q;
  assign reloading           = reloading_q;
  assign ready               = ready_q;

endmodule

// File: tb/tb_magazine_ctrl.sv
// ---------------------------------------------------------------------------
// tb_magazine_ctrl
//
// Drives magazine_ctrl (MAG_SIZE=3, COOLDOWN_CYCLES=4, RELOAD_CYCLES=8)
// through a set of directed gameplay scenarios and then random button
// traffic. A behavioural reference model tracks the magazine with
// deadlines ("lockout ends at cycle N", "next round due at cycle M") and
// predicts every output after every clock edge.
// ---------------------------------------------------------------------------
module tb_magazine_ctrl;

  localparam int MAG  = 3;
  localparam int COOL = 4;
  localparam int RLD  = 8;

  // Reference model modes.
  localparam int M_OFF    = 0;
  localparam int M_READY  = 1;
  localparam int M_COOL   = 2;
  localparam int M_RELOAD = 3;

  logic       clk;
  logic       rst;
  logic       game_enable;
  logic       round_start;
  logic       trigger;
  logic       reload_btn;
  logic [2:0] bullets_in_magazine;
  logic       shot_fired;
  logic       dry_fire;
  logic       reloading;
  logic       ready;

  magazine_ctrl #(
    .MAG_SIZE       (MAG),
    .COOLDOWN_CYCLES(COOL),
    .RELOAD_CYCLES  (RLD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .game_enable        (game_enable),
    .round_start        (round_start),
    .trigger            (trigger),
    .reload_btn         (reload_btn),
    .bullets_in_magazine(bullets_in_magazine),
    .shot_fired         (shot_fired),
    .dry_fire           (dry_fire),
    .reloading          (reloading),
    .ready              (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;   // clock edge counter

  // Model state.
  int m_mode    = M_OFF;
  int m_bul     = MAG;
  int m_shot    = 0;
  int m_dry     = 0;
  int m_cool_at = 0;   // edge at which the lockout ends
  int m_due     = 0;   // edge at which the next round is inserted
  int m_ptrig   = 0;
  int m_prld    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at edge %0d", tag, got, exp, n);
    end
  endtask

  task automatic model_fire();
    m_shot    = 1;
    m_bul     = m_bul - 1;
    m_mode    = M_COOL;
    m_cool_at = n + COOL;
  endtask

  task automatic model_step(input bit r, input bit e, input bit s, input bit t, input bit l);
    bit tp;
    bit lp;
    tp     = t && (m_ptrig == 0);
    lp     = l && (m_prld == 0);
    m_shot = 0;
    m_dry  = 0;
    if (r) begin
      m_mode  = M_OFF;
      m_bul   = MAG;
      m_ptrig = 0;
      m_prld  = 0;
    end else begin
      m_ptrig = int'(t);
      m_prld  = int'(l);
      if (!e) begin
        m_mode = M_OFF;
        m_bul  = MAG;
      end else if (s) begin
        m_mode = M_READY;
        m_bul  = MAG;
      end else begin
        case (m_mode)
          M_OFF: m_mode = M_READY;
          M_READY: begin
            if (tp) begin
              if (m_bul > 0) model_fire();
              else m_dry = 1;
            end else if (lp && m_bul < MAG) begin
              m_mode = M_RELOAD;
              m_due  = n + RLD;
            end
          end
          M_COOL: begin
            if (n >= m_cool_at) m_mode = M_READY;
          end
          default: begin
            if (tp && m_bul > 0) begin
              model_fire();
            end else begin
              if (tp) m_dry = 1;
              if (n >= m_due) begin
                m_bul = m_bul + 1;
                if (m_bul == MAG) m_mode = M_READY;
                else m_due = n + RLD;
              end
            end
          end
        endcase
      end
    end
  endtask

  // One clock: apply inputs, advance the model at the edge, compare #1 later.
  task automatic tick(input bit r, input bit e, input bit s, input bit t, input bit l);
    rst         = r;
    game_enable = e;
    round_start = s;
    trigger     = t;
    reload_btn  = l;
    @(posedge clk);
    n++;
    model_step(r, e, s, t, l);
    #1;
    check("bullets", 32'(bullets_in_magazine), 32'(m_bul));
    check("shot", 32'(shot_fired), 32'(m_shot));
    check("dry", 32'(dry_fire), 32'(m_dry));
    check("reloading", 32'(reloading), 32'(m_mode == M_RELOAD));
    check("ready", 32'(ready), 32'((m_mode == M_READY) && (m_bul > 0)));
    check("exclusive", 32'(shot_fired & dry_fire), 32'd0);
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press_trig();
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic press_reload();
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    int tdiv;
    rst = 1'b1; game_enable = 1'b0; round_start = 1'b0;
    trigger = 1'b0; reload_btn = 1'b0;

    // Reset state.
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_bullets", 32'(bullets_in_magazine), 32'd3);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_reloading", 32'(reloading), 32'd0);
    $display("scenario reset: bullets=%0d ready=%0d", bullets_in_magazine, ready);

    // Enable, three spaced shots, then a dry fire.
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("en_ready", 32'(ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      press_trig();
      check("shot_seq_count", 32'(bullets_in_magazine), 32'(2 - i));
      check("shot_seq_pulse", 32'(shot_fired), 32'd1);
      idle(5);
    end
    press_trig();
    check("dry_pulse", 32'(dry_fire), 32'd1);
    check("dry_count", 32'(bullets_in_magazine), 32'd0);
    idle(1);
    $display("scenario shots: bullets=%0d", bullets_in_magazine);

    // Full reload from empty.
    press_reload();
    check("reload_start", 32'(reloading), 32'd1);
    idle(8);
    check("reload_r1", 32'(bullets_in_magazine), 32'd1);
    idle(8);
    check("reload_r2", 32'(bullets_in_magazine), 32'd2);
    idle(8);
    check("reload_r3", 32'(bullets_in_magazine), 32'd3);
    check("reload_ready", 32'(ready), 32'd1);
    check("reload_done", 32'(reloading), 32'd0);
    $display("scenario reload: bullets=%0d ready=%0d", bullets_in_magazine, ready);

    // Presses during cooldown are ignored; after the lockout one is accepted.
    press_trig();
    idle(1);
    press_trig();
    check("cool_ignored_shot", 32'(shot_fired), 32'd0);
    check("cool_ignored_count", 32'(bullets_in_magazine), 32'd2);
    idle(2);
    press_trig();
    check("cool_accept_shot", 32'(shot_fired), 32'd1);
    check("cool_accept_count", 32'(bullets_in_magazine), 32'd1);
    idle(5);
    press_trig();
    idle(5);
    $display("scenario cooldown: bullets=%0d", bullets_in_magazine);

    // Trigger in the middle of the second reload round aborts it.
    press_reload();
    idle(8);
    check("abort_r1", 32'(bullets_in_magazine), 32'd1);
    idle(4);
    press_trig();
    check("abort_shot", 32'(shot_fired), 32'd1);
    check("abort_count", 32'(bullets_in_magazine), 32'd0);
    check("abort_reloading", 32'(reloading), 32'd0);
    idle(10);
    check("abort_no_round", 32'(bullets_in_magazine), 32'd0);
    $display("scenario abort: bullets=%0d", bullets_in_magazine);

    // round_start mid-reload refills immediately.
    press_reload();
    idle(8);
    idle(3);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rs_count", 32'(bullets_in_magazine), 32'd3);
    check("rs_ready", 32'(ready), 32'd1);
    check("rs_reloading", 32'(reloading), 32'd0);

    // game_enable dropped mid-cooldown.
    press_trig();
    idle(1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("dis_count", 32'(bullets_in_magazine), 32'd3);
    check("dis_shot", 32'(shot_fired), 32'd0);
    check("dis_ready", 32'(ready), 32'd0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reen_ready", 32'(ready), 32'd1);

    // rst mid-reload.
    press_trig();
    idle(5);
    press_reload();
    idle(3);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_mid_count", 32'(bullets_in_magazine), 32'd3);
    check("rst_mid_reloading", 32'(reloading), 32'd0);
    check("rst_mid_ready", 32'(ready), 32'd0);
    $display("scenario interrupts: bullets=%0d", bullets_in_magazine);

    // Random traffic; trigger gets sparser in the second half so that
    // reloads run to completion more often.
    for (int i = 0; i < 3000; i++) begin
      tdiv = (i < 1500) ? 2 : 11;
      tick($urandom_range(0, 299) == 0,
           $urandom_range(0, 79) != 0,
           $urandom_range(0, 69) == 0,
           $urandom_range(0, tdiv) == 0,
           $urandom_range(0, 3) == 0);
    end
    $display("random phase: %0d edges", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
